case_9_mul_share_arb: RTL and testbench
=======================================

// Module: case_9_mul_share_arb
// PURPOSE
//  - Shares one signed DIN0_WIDTH x DIN1_WIDTH multiplier among NUM_REQ requesters.
//  - Uses a round-robin grant, a 2-stage valid/ready pipeline and a tagged response port.
//  - Sits between the case_9 datapath lanes and a single multiplier resource, replacing per-lane multipliers.
//  - Sustains 1 product/cycle when the response side is ready.
// PARAMETERS
//  - NUM_REQ     4  number of requesters (2..8)
//  - DIN0_WIDTH  9  signed operand A width
//  - DIN1_WIDTH  3  signed operand B width
//  - DOUT_WIDTH  9  result width, truncated or saturated from the full product
//  - ID_WIDTH    2  response tag width; must be >= clog2(NUM_REQ)
// PORTS
//  - ap_clk     in   1                     clock; all logic on the rising edge
//  - ap_rst     in   1                     reset; asynchronous, active-high
//  - req_valid  in   NUM_REQ               per-requester operand valid
//  - req_ready  out  NUM_REQ               per-requester accept, one-hot or zero
//  - req_din0   in   NUM_REQ*DIN0_WIDTH    operand A; lane i = [i*DIN0_WIDTH +: DIN0_WIDTH]
//  - req_din1   in   NUM_REQ*DIN1_WIDTH    operand B; lane i = [i*DIN1_WIDTH +: DIN1_WIDTH]
//  - rsp_valid  out  1                     result valid
//  - rsp_ready  in   1                     result consumed
//  - rsp_id     out  ID_WIDTH              index of the requester that owns the result
//  - rsp_dout   out  DOUT_WIDTH            signed result
//  - rsp_sat    out  1                     result was clamped (only with saturation compiled in)
// BEHAVIOUR
//  - Reset (async assert):
//    - s1_v = 0, s2_v = 0, rr_ptr = 0
//    - rsp_valid = 0, rsp_id = 0, rsp_dout = 0, rsp_sat = 0
//    - In-flight operations are dropped with no response.
//  - Transfer rule: a handshake completes only when valid & ready in the same cycle.
//    - req_ready never depends combinationally on its own lane's req_din*.
//  - Pipeline advance:
//    - adv2 = s1_v & (~s2_v | rsp_ready)
//    - adv1 = ~s1_v | adv2
//  - Arbitration:
//    - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; first hit = g.
//    - req_ready[g] = adv1. All other bits of req_ready are 0.
//  - On accept (req_valid[g] & req_ready[g]):
//    - Latch lane g operands and g into stage 1; s1_v <= 1.
//    - rr_ptr <= (g+1) mod NUM_REQ.
//    - If there is no accept, rr_ptr holds.
//  - Stage 2 (on adv2):
//    - prod = $signed(a) * $signed(b), full DIN0_WIDTH+DIN1_WIDTH bits.
//    - Register the result into rsp_dout/rsp_sat/rsp_id; s2_v <= 1.
//    - If adv1 fires without an accept, s1_v <= 0.
//    - If rsp_valid & rsp_ready fire without a new adv2, s2_v <= 0.
//  - Latency: accept at edge N -> rsp_valid high after edge N+1, i.e. 2 cycles.
//    - Back-to-back accepts give back-to-back responses.
//  - Backpressure:
//    - rsp_ready low holds rsp_* stable; stage 1 fills, then every req_ready drops.
//    - Nothing is lost or duplicated.
//  - Fairness: a continuously-valid requester is granted within NUM_REQ accepts.
// CONFIGURATION
//  - Macro CASE9_MUL_SHARE_SAT_EN.
//  - Defined:
//    - rsp_dout = prod clamped to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1].
//    - rsp_sat = 1 when the clamp is applied.
//  - Undefined:
//    - rsp_dout = prod[DOUT_WIDTH-1:0] (two's-complement wrap).
//    - rsp_sat tied to 0.
// STRUCTURE
//  - Package case_9_mul_share_pkg:
//    - Localparams PROD_WIDTH = DIN0_WIDTH+DIN1_WIDTH, SAT_MAX, SAT_MIN.
//    - Typedef of the stage-1 record {id, a, b}.
//  - Sub-module case_9_mul_share_rr_pick: combinational rotate-priority picker.
//    - Inputs: req vector, rr_ptr.
//    - Outputs: one-hot grant, binary index g, any.
//  - Multiply, truncate/saturate and the pipeline stay in the top level.
// TESTING
//  - Reset mid-flight: accept lane 1, then pulse ap_rst -> rsp_valid stays 0; rr_ptr = 0; next grant goes to lane 0.
//  - Single op: lane 2, din0 = -7, din1 = 3 -> 2 cycles later rsp_valid = 1, rsp_id = 2, rsp_dout = -21, rsp_sat = 0.
//  - Overflow, lane 0, 100*3:
//    - Without the macro: rsp_dout = 9'h12C (-212), rsp_sat = 0.
//    - With the macro: rsp_dout = 255, rsp_sat = 1.
//  - Overflow, lane 0, -256*-4:
//    - Without the macro: rsp_dout = 0.
//    - With the macro: rsp_dout = 255, rsp_sat = 1.
//  - Round-robin: all 4 lanes valid continuously, rsp_ready = 1 -> rsp_id sequence 0,1,2,3,0,..., one response per cycle.
//  - Backpressure: rsp_ready = 0 for 5 cycles with all lanes valid:
//    - Exactly 2 accepts occur; rsp_* stay stable.
//    - After release, responses arrive in accept order with no gaps.

Source files
------------

// File: rtl/case_9_mul_share_pkg.sv
// Shared constants, stage-1 record and the saturating clamp for the shared multiplier.
// Clamping is selected in the top level by the CASE9_MUL_SHARE_SAT_EN macro.
package case_9_mul_share_pkg;

  localparam int NUM_REQ    = 4;
  localparam int DIN0_WIDTH = 9;
  localparam int DIN1_WIDTH = 3;
  localparam int DOUT_WIDTH = 9;
  localparam int ID_WIDTH   = 2;

  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;
  localparam int SAT_MAX    = (1 << (DOUT_WIDTH - 1)) - 1;
  localparam int SAT_MIN    = -(1 << (DOUT_WIDTH - 1));

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DIN0_WIDTH-1:0] a;
    logic [DIN1_WIDTH-1:0] b;
  } s1_rec_t;

  // Returns {clamped, value}.
  function automatic logic [DOUT_WIDTH:0] sat_clamp(input logic signed [PROD_WIDTH-1:0] p);
    if (int'(p) > SAT_MAX) begin
      return {1'b1, DOUT_WIDTH'(SAT_MAX)};
    end else if (int'(p) < SAT_MIN) begin
      return {1'b1, DOUT_WIDTH'(SAT_MIN)};
    end
    return {1'b0, DOUT_WIDTH'(p)};
  endfunction

endpackage

// File: rtl/case_9_mul_share_rr_pick.sv
// Rotate-priority picker: first asserted request at or after ptr_i, wrapping.
// Produces a one-hot grant, its binary index and an any-request flag.
module case_9_mul_share_rr_pick
  import case_9_mul_share_pkg::*;
#(
  parameter int N  = NUM_REQ,
  parameter int IW = ID_WIDTH
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             j;

  // Rotating a doubled copy puts the pointer lane at bit 0, so the lowest set bit wins.
  always_comb begin
    dbl = {req_i, req_i};
    rot = N'(dbl >> ptr_i);
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        j = int'(ptr_i) + k;
      end
    end
    if (j >= N) begin
      j = j - N;
    end
    any_o = |req_i;
    idx_o = any_o ? IW'(j) : '0;
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/case_9_mul_share_arb.sv
// One signed multiplier shared by NUM_REQ lanes: round-robin grant, 2-stage pipeline, tagged response.
// Define CASE9_MUL_SHARE_SAT_EN to clamp results instead of wrapping them.
module case_9_mul_share_arb
  import case_9_mul_share_pkg::*;
(
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]  req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]  req_din1,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [DOUT_WIDTH-1:0]          rsp_dout,
  output logic                           rsp_sat
);

  logic [NUM_REQ-1:0]      gnt;
  logic [ID_WIDTH-1:0]     g;
  logic                    any;
  logic                    adv1, adv2, accept;

  s1_rec_t                 s1_q, s1_d;
  logic                    s1_v_q, s1_v_d;
  logic                    s2_v_q, s2_v_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]     rsp_id_q, rsp_id_d;
  logic [DOUT_WIDTH-1:0]   rsp_dout_q, rsp_dout_d;
  logic                    rsp_sat_q, rsp_sat_d;

  logic signed [PROD_WIDTH-1:0] prod;
  logic [DOUT_WIDTH-1:0]   res;
  logic                    res_sat;

  case_9_mul_share_rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_WIDTH)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (g),
    .any_o (any)
  );

  // The grant only looks at valids and pipeline occupancy, never at operand data.
  assign adv2      = s1_v_q & (~s2_v_q | rsp_ready);
  assign adv1      = ~s1_v_q | adv2;
  assign req_ready = adv1 ? gnt : '0;
  assign accept    = any & adv1;

  always_comb begin
    prod = PROD_WIDTH'($signed(s1_q.a)) * PROD_WIDTH'($signed(s1_q.b));
`ifdef CASE9_MUL_SHARE_SAT_EN
    {res_sat, res} = sat_clamp(prod);
`else
    res     = DOUT_WIDTH'(prod);
    res_sat = 1'b0;
`endif
  end

  always_comb begin
    s1_v_d     = s1_v_q;
    s1_d       = s1_q;
    rr_ptr_d   = rr_ptr_q;
    s2_v_d     = s2_v_q;
    rsp_id_d   = rsp_id_q;
    rsp_dout_d = rsp_dout_q;
    rsp_sat_d  = rsp_sat_q;

    if (accept) begin
      s1_v_d   = 1'b1;
      s1_d.id  = g;
      s1_d.a   = req_din0[int'(g)*DIN0_WIDTH +: DIN0_WIDTH];
      s1_d.b   = req_din1[int'(g)*DIN1_WIDTH +: DIN1_WIDTH];
      rr_ptr_d = (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
    end else if (adv1) begin
      s1_v_d = 1'b0;
    end

    if (adv2) begin
      s2_v_d     = 1'b1;
      rsp_id_d   = s1_q.id;
      rsp_dout_d = res;
      rsp_sat_d  = res_sat;
    end else if (rsp_ready) begin
      s2_v_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s1_v_q     <= 1'b0;
      s1_q       <= '0;
      rr_ptr_q   <= '0;
      s2_v_q     <= 1'b0;
      rsp_id_q   <= '0;
      rsp_dout_q <= '0;
      rsp_sat_q  <= 1'b0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_q       <= s1_d;
      rr_ptr_q   <= rr_ptr_d;
      s2_v_q     <= s2_v_d;
      rsp_id_q   <= rsp_id_d;
      rsp_dout_q <= rsp_dout_d;
      rsp_sat_q  <= rsp_sat_d;
    end
  end

  assign rsp_valid = s2_v_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_dout  = rsp_dout_q;
  assign rsp_sat   = rsp_sat_q;

endmodule

// File: tb/tb_case_9_mul_share_arb.sv
// Directed bench for case_9_mul_share_arb: reset, single ops, overflow, round-robin, backpressure.
// Expected overflow results follow CASE9_MUL_SHARE_SAT_EN when it is defined for the build.
module tb_case_9_mul_share_arb;
  import case_9_mul_share_pkg::*;

  logic                          ap_clk;
  logic                          ap_rst;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic [DOUT_WIDTH-1:0]         rsp_dout;
  logic                          rsp_sat;

  int checks   = 0;
  int failures = 0;
  int accepts  = 0;

  logic [NUM_REQ-1:0] bpReady [5];

  case_9_mul_share_arb dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din0  (req_din0),
    .req_din1  (req_din1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_dout  (rsp_dout),
    .rsp_sat   (rsp_sat)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic rdy);
    req_valid = valid;
    rsp_ready = rdy;
    #1;
  endtask

  task automatic setLane(input int lane, input logic [DIN0_WIDTH-1:0] a, input logic [DIN1_WIDTH-1:0] b);
    req_din0[lane*DIN0_WIDTH +: DIN0_WIDTH] = a;
    req_din1[lane*DIN1_WIDTH +: DIN1_WIDTH] = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bpReady[0] = 4'b0001;
    bpReady[1] = 4'b0010;
    bpReady[2] = 4'b0000;
    bpReady[3] = 4'b0000;
    bpReady[4] = 4'b0000;

    ap_rst    = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_din0  = '0;
    req_din1  = '0;
    tick();
    tick();
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_id", rsp_id, 0);
    checkOutput("rst_rsp_dout", rsp_dout, 0);
    checkOutput("rst_rsp_sat", rsp_sat, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    ap_rst = 1'b0;
    tick();

    // Reset mid-flight: lane 1 accepted, then dropped by an async reset pulse.
    setLane(1, 9'd5, 3'd1);
    applyStimulus(4'b0010, 1'b1);
    checkOutput("mid_ready_l1", req_ready, 4'b0010);
    tick();
    applyStimulus(4'b0000, 1'b1);
    ap_rst = 1'b1;
    #2;
    ap_rst = 1'b0;
    #1;
    checkOutput("mid_rsp_valid_a", rsp_valid, 0);
    tick();
    checkOutput("mid_rsp_valid_b", rsp_valid, 0);

    // Overflow 100*3 on lane 0; grant must restart at lane 0 after reset.
    setLane(0, 9'd100, 3'd3);
    applyStimulus(4'b0011, 1'b1);
    checkOutput("ptr_reset_ready", req_ready, 4'b0001);
    tick();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("ovf1_latency", rsp_valid, 0);
    tick();
    checkOutput("ovf1_valid", rsp_valid, 1);
    checkOutput("ovf1_id", rsp_id, 0);
`ifdef CASE9_MUL_SHARE_SAT_EN
    checkOutput("ovf1_dout", rsp_dout, 9'h0FF);
    checkOutput("ovf1_sat", rsp_sat, 1);
`else
    checkOutput("ovf1_dout", rsp_dout, 9'h12C);
    checkOutput("ovf1_sat", rsp_sat, 0);
`endif

    // Single op: lane 2, -7 * 3 = -21.
    setLane(2, 9'h1F9, 3'b011);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("single_ready", req_ready, 4'b0100);
    tick();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_latency", rsp_valid, 0);
    tick();
    checkOutput("single_valid", rsp_valid, 1);
    checkOutput("single_id", rsp_id, 2);
    checkOutput("single_dout", rsp_dout, 9'h1EB);
    checkOutput("single_sat", rsp_sat, 0);

    // Overflow -256 * -4 on lane 0; pointer sits at 3 and wraps to 0.
    setLane(0, 9'h100, 3'b100);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("ovf2_ready", req_ready, 4'b0001);
    tick();
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("ovf2_valid", rsp_valid, 1);
    checkOutput("ovf2_id", rsp_id, 0);
`ifdef CASE9_MUL_SHARE_SAT_EN
    checkOutput("ovf2_dout", rsp_dout, 9'h0FF);
    checkOutput("ovf2_sat", rsp_sat, 1);
`else
    checkOutput("ovf2_dout", rsp_dout, 9'h000);
    checkOutput("ovf2_sat", rsp_sat, 0);
`endif
    tick();
    checkOutput("drain_valid", rsp_valid, 0);

    // Round-robin with all lanes valid: lane i computes 10*(i+1) * 2.
    ap_rst = 1'b1;
    #2;
    ap_rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      setLane(i, 9'(10 * (i + 1)), 3'd2);
    end
    applyStimulus(4'b1111, 1'b1);
    for (int k = 0; k < 8; k++) begin
      checkOutput("rr_ready", req_ready, 32'(1 << (k % 4)));
      tick();
      if (k >= 1) begin
        checkOutput("rr_valid", rsp_valid, 1);
        checkOutput("rr_id", rsp_id, 32'((k - 1) % 4));
        checkOutput("rr_dout", rsp_dout, 32'(20 * ((k - 1) % 4 + 1)));
      end
    end
    applyStimulus(4'b0000, 1'b1);
    tick();
    tick();
    checkOutput("rr_drain", rsp_valid, 0);

    // Backpressure: pointer is back at 0, response side stalled for 5 cycles.
    applyStimulus(4'b1111, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_ready", req_ready, 32'(bpReady[k]));
      accepts += $countones(req_valid & req_ready);
      tick();
      if (k >= 1) begin
        checkOutput("bp_hold_valid", rsp_valid, 1);
        checkOutput("bp_hold_id", rsp_id, 0);
        checkOutput("bp_hold_dout", rsp_dout, 9'h014);
      end
    end
    checkOutput("bp_accepts", accepts, 2);

    applyStimulus(4'b0000, 1'b1);
    checkOutput("rel_first_id", rsp_id, 0);
    tick();
    checkOutput("rel_second_valid", rsp_valid, 1);
    checkOutput("rel_second_id", rsp_id, 1);
    checkOutput("rel_second_dout", rsp_dout, 9'h028);
    tick();
    checkOutput("rel_empty", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
